epmp_cu_v2: RTL and testbench

- Parametrised next-generation control unit for the EPMP 8-bit educational processor.
- Decodes IR (group = IR[7:4], sub = IR[3:0]) and sequences fetch, operand, data, jump and stack micro-steps.
- Adds over the previous CU: a Mem_Ready wait handshake with a timeout watchdog, stack-occupancy tracking with overflow/underflow faults, a HALT instruction, a sticky fault state, and a Step-pulse debug stepper.
- Sits between the IR/C flag and the datapath register enables.

---
 rtl/epmp_cu_v2.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_epmp_cu_v2.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epmp_cu_v2.sv
// epmp_cu_v2: control unit for the EPMP 8-bit processor.
// Decodes IR into fetch/operand/data/jump/stack micro-steps. It adds a Mem_Ready
// handshake with a timeout watchdog, stack occupancy tracking, HALT, a sticky
// FAULT state and a single-step debugger.
// Optional feature: define EPMP_CU_BREAKPOINT_EN to add the PC breakpoint ports
// (PC_Value, Bp_Addr, Bp_Enable).
module epmp_cu_v2 #(
  parameter int STACK_DEPTH = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int SL_W        = 5,
  parameter int PC_W        = 8
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [7:0]      IR,
  input  logic            C,
  input  logic            Mem_Ready,
  input  logic [1:0]      Debug_Mode,
  input  logic            Step,
  input  logic            Resume,
`ifdef EPMP_CU_BREAKPOINT_EN
  input  logic [PC_W-1:0] PC_Value,
  input  logic [PC_W-1:0] Bp_Addr,
  input  logic            Bp_Enable,
`endif
  output logic [3:0]      ALU_Cmd,
  output logic            PC_Out_En,
  output logic            PC_Load_En,
  output logic            PC_Inc_nLoad,
  output logic            IR_Load,
  output logic            ALU_En,
  output logic            ACC_Out_En,
  output logic            MAR_Load,
  output logic            Read,
  output logic            Write,
  output logic            MDR_XB_Load,
  output logic            MDR_IB_Load,
  output logic            MDR_XB_En,
  output logic            MDR_IB_En,
  output logic            AuxR_Load_En,
  output logic            AuxR_Out_En,
  output logic            Push_Stack,
  output logic            Pop_Stack,
  output logic            Halted,
  output logic            Fault,
  output logic [2:0]      Fault_Code,
  output logic [SL_W-1:0] Stack_Level,
  output logic [4:0]      Debug_State
);

  // Parameter sanity: the occupancy counter must be able to hold STACK_DEPTH.
  if ((2 ** SL_W) <= STACK_DEPTH || PC_W < 1) begin : g_bad_params
    $error("epmp_cu_v2: SL_W too small for STACK_DEPTH or PC_W < 1");
  end

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [4:0] {
    S_F0    = 5'd0,  S_F1  = 5'd1,  S_F2  = 5'd2,  S_EX   = 5'd3,
    S_A0    = 5'd4,  S_A1  = 5'd5,  S_A2  = 5'd6,  S_D0   = 5'd7,
    S_D1    = 5'd8,  S_D2  = 5'd9,  S_W0  = 5'd10, S_W1   = 5'd11,
    S_W2    = 5'd12, S_JMP = 5'd13, S_NC  = 5'd14, S_PUSH = 5'd15,
    S_POP   = 5'd16, S_HALT = 5'd17, S_FAULT = 5'd18
  } state_t;

  state_t          state, state_n;
  logic [2:0]      fault_code, fault_code_n;
  logic [SL_W-1:0] stack_lvl;
  logic [WD_W-1:0] wd_cnt;
  logic            adv, wait_st, wd_expire;
  logic [3:0]      grp, sub;

  // Ungated strobes; all are forced low while nReset is asserted.
  logic pc_out_en, pc_load_en, pc_inc_nload, ir_load, alu_en, acc_out_en;
  logic mar_load, rd, wr, mdr_xb_load, mdr_ib_load, mdr_xb_en, mdr_ib_en;
  logic auxr_load_en, auxr_out_en, push_stack, pop_stack;
  logic bp_hit, bp_match;

  assign grp     = IR[7:4];
  assign sub     = IR[3:0];
  assign wait_st = (state == S_F1) || (state == S_A1) || (state == S_D1) || (state == S_W2);

`ifdef EPMP_CU_BREAKPOINT_EN
  assign bp_match = Bp_Enable && (PC_Value == Bp_Addr);

  // Remember that HALT was entered from a breakpoint so Resume skips F0.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                                     bp_hit <= 1'b0;
    else if (state == S_F0 && state_n == S_HALT)     bp_hit <= 1'b1;
    else if (state == S_HALT && state_n != S_HALT)   bp_hit <= 1'b0;
  end
`else
  assign bp_match = 1'b0;
  assign bp_hit   = 1'b0;
`endif

  // Advance enable from the debug stepping mode.
  always_comb begin
    adv = 1'b1;
    case (Debug_Mode)
      2'd0:    adv = 1'b1;
      2'd1:    adv = (state == S_F2) ? Step : 1'b1;
      2'd2:    adv = wait_st ? Step : 1'b1;
      default: adv = Step;
    endcase
  end

  // Watchdog fires when the stall that would reach MEM_TIMEOUT still has no Mem_Ready.
  assign wd_expire = (MEM_TIMEOUT != 0) && wait_st && adv && !Mem_Ready &&
                     (wd_cnt == WD_W'(MEM_TIMEOUT - 1));

  // Next state, fault code and datapath strobes.
  always_comb begin
    state_n      = state;
    fault_code_n = fault_code;
    pc_out_en    = 1'b0;  pc_load_en   = 1'b0;  pc_inc_nload = 1'b1;
    ir_load      = 1'b0;  alu_en       = 1'b0;  acc_out_en   = 1'b0;
    mar_load     = 1'b0;  rd           = 1'b0;  wr           = 1'b0;
    mdr_xb_load  = 1'b0;  mdr_ib_load  = 1'b0;  mdr_xb_en    = 1'b0;
    mdr_ib_en    = 1'b0;  auxr_load_en = 1'b0;  auxr_out_en  = 1'b0;
    push_stack   = 1'b0;  pop_stack    = 1'b0;
    case (state)
      S_F0: begin
        pc_out_en = 1'b1;
        mar_load  = adv;
        if (adv) state_n = bp_match ? S_HALT : S_F1;
      end
      S_F1, S_A1, S_D1: begin
        rd          = 1'b1;
        mdr_xb_load = adv && Mem_Ready;
        if (adv && Mem_Ready)
          state_n = (state == S_F1) ? S_F2 : (state == S_A1) ? S_A2 : S_D2;
      end
      S_F2: begin
        mdr_ib_en  = 1'b1;
        ir_load    = adv;
        pc_load_en = adv;
        if (adv) state_n = S_EX;
      end
      S_EX: begin
        alu_en = adv && (grp == 4'd2);
        if (adv) begin
          case (grp)
            4'd0, 4'd1: state_n = S_A0;
            4'd2:       state_n = S_F0;
            4'd3:       state_n = (sub == 4'd1 && !C) ? S_NC : S_A0;
            4'd4: begin
              if (sub == 4'd2) begin
                if (stack_lvl == SL_W'(STACK_DEPTH)) begin
                  state_n = S_FAULT; fault_code_n = 3'd1;
                end else state_n = S_PUSH;
              end else if (sub == 4'd1) begin
                if (stack_lvl == '0) begin
                  state_n = S_FAULT; fault_code_n = 3'd2;
                end else state_n = S_POP;
              end else begin
                state_n = S_FAULT; fault_code_n = 3'd3;
              end
            end
            4'd5:       state_n = S_HALT;
            default: begin
              state_n = S_FAULT; fault_code_n = 3'd3;
            end
          endcase
        end
      end
      S_A0: begin
        pc_out_en = 1'b1;
        mar_load  = adv;
        if (adv) state_n = S_A1;
      end
      S_A2: begin
        mdr_ib_en    = 1'b1;
        auxr_load_en = adv;
        pc_load_en   = adv;
        if (adv) begin
          case (grp)
            4'd3:    state_n = S_JMP;
            4'd0:    state_n = S_D0;
            4'd1:    state_n = S_W0;
            default: begin
              state_n = S_FAULT; fault_code_n = 3'd3;
            end
          endcase
        end
      end
      S_D0, S_W0: begin
        auxr_out_en = 1'b1;
        mar_load    = adv;
        if (adv) state_n = (state == S_D0) ? S_D1 : S_W1;
      end
      S_D2: begin
        mdr_ib_en = 1'b1;
        alu_en    = adv;
        if (adv) state_n = S_F0;
      end
      S_W1: begin
        acc_out_en  = 1'b1;
        mdr_ib_load = adv;
        if (adv) state_n = S_W2;
      end
      S_W2: begin
        mdr_xb_en = 1'b1;
        wr        = 1'b1;
        if (adv && Mem_Ready) state_n = S_F0;
      end
      S_JMP: begin
        auxr_out_en  = 1'b1;
        pc_load_en   = adv;
        pc_inc_nload = 1'b0;
        if (adv) state_n = S_F0;
      end
      S_NC: begin
        pc_load_en = adv;
        if (adv) state_n = S_F0;
      end
      S_PUSH: begin
        push_stack = adv;
        if (adv) state_n = S_F0;
      end
      S_POP: begin
        pop_stack = adv;
        alu_en    = adv;
        if (adv) state_n = S_F0;
      end
      S_HALT: begin
        if (Resume) state_n = bp_hit ? S_F1 : S_F0;
      end
      S_FAULT: state_n = S_FAULT;
      default: begin
        state_n = S_FAULT; fault_code_n = 3'd3;
      end
    endcase
    if (wd_expire) begin
      state_n      = S_FAULT;
      fault_code_n = 3'd4;
    end
  end

  // State and latched fault code.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= S_F0;
      fault_code <= 3'd0;
    end else begin
      state      <= state_n;
      fault_code <= fault_code_n;
    end
  end

  // Watchdog: cleared on every state change, counts stalled advancing cycles.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                                  wd_cnt <= '0;
    else if (state_n != state)                    wd_cnt <= '0;
    else if (wait_st && adv && !Mem_Ready && MEM_TIMEOUT != 0)
                                                  wd_cnt <= wd_cnt + 1'b1;
  end

  // Stack occupancy follows completed PUSH/POP micro-steps.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                      stack_lvl <= '0;
    else if (state == S_PUSH && adv)  stack_lvl <= stack_lvl + 1'b1;
    else if (state == S_POP && adv)   stack_lvl <= stack_lvl - 1'b1;
  end

  assign ALU_Cmd      = IR[3:0];
  assign PC_Out_En    = pc_out_en    & nReset;
  assign PC_Load_En   = pc_load_en   & nReset;
  assign PC_Inc_nLoad = pc_inc_nload & nReset;
  assign IR_Load      = ir_load      & nReset;
  assign ALU_En       = alu_en       & nReset;
  assign ACC_Out_En   = acc_out_en   & nReset;
  assign MAR_Load     = mar_load     & nReset;
  assign Read         = rd           & nReset;
  assign Write        = wr           & nReset;
  assign MDR_XB_Load  = mdr_xb_load  & nReset;
  assign MDR_IB_Load  = mdr_ib_load  & nReset;
  assign MDR_XB_En    = mdr_xb_en    & nReset;
  assign MDR_IB_En    = mdr_ib_en    & nReset;
  assign AuxR_Load_En = auxr_load_en & nReset;
  assign AuxR_Out_En  = auxr_out_en  & nReset;
  assign Push_Stack   = push_stack   & nReset;
  assign Pop_Stack    = pop_stack    & nReset;
  assign Halted       = (state == S_HALT);
  assign Fault        = (state == S_FAULT);
  assign Fault_Code   = fault_code;
  assign Stack_Level  = stack_lvl;
  assign Debug_State  = state;

endmodule

// File: tb/tb_epmp_cu_v2.sv
// Scoreboard bench for epmp_cu_v2: each cycle the stimulus side predicts the
// visible micro-step and strobes from per-instruction step lists, and a
// monitor on the falling edge compares them with the DUT.
module tb_epmp_cu_v2;
  localparam int STACK_DEPTH = 16;
  localparam int MEM_TIMEOUT = 15;
  localparam int SL_W        = 5;
  localparam int PC_W        = 8;

  logic            clk = 1'b0;
  logic            nReset = 1'b0;
  logic [7:0]      IR = 8'h00;
  logic            C = 1'b0;
  logic            Mem_Ready = 1'b0;
  logic [1:0]      Debug_Mode = 2'd0;
  logic            Step = 1'b0;
  logic            Resume = 1'b0;
`ifdef EPMP_CU_BREAKPOINT_EN
  logic [PC_W-1:0] PC_Value = '0;
  logic [PC_W-1:0] Bp_Addr = '0;
  logic            Bp_Enable = 1'b0;
`endif
  logic [3:0]      ALU_Cmd;
  logic PC_Out_En, PC_Load_En, PC_Inc_nLoad, IR_Load, ALU_En, ACC_Out_En, MAR_Load;
  logic Read, Write, MDR_XB_Load, MDR_IB_Load, MDR_XB_En, MDR_IB_En;
  logic AuxR_Load_En, AuxR_Out_En, Push_Stack, Pop_Stack, Halted, Fault;
  logic [2:0]      Fault_Code;
  logic [SL_W-1:0] Stack_Level;
  logic [4:0]      Debug_State;

  epmp_cu_v2 #(.STACK_DEPTH(STACK_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT), .SL_W(SL_W), .PC_W(PC_W)) dut (
    .clk(clk), .nReset(nReset), .IR(IR), .C(C), .Mem_Ready(Mem_Ready),
    .Debug_Mode(Debug_Mode), .Step(Step), .Resume(Resume),
`ifdef EPMP_CU_BREAKPOINT_EN
    .PC_Value(PC_Value), .Bp_Addr(Bp_Addr), .Bp_Enable(Bp_Enable),
`endif
    .ALU_Cmd(ALU_Cmd), .PC_Out_En(PC_Out_En), .PC_Load_En(PC_Load_En),
    .PC_Inc_nLoad(PC_Inc_nLoad), .IR_Load(IR_Load), .ALU_En(ALU_En),
    .ACC_Out_En(ACC_Out_En), .MAR_Load(MAR_Load), .Read(Read), .Write(Write),
    .MDR_XB_Load(MDR_XB_Load), .MDR_IB_Load(MDR_IB_Load), .MDR_XB_En(MDR_XB_En),
    .MDR_IB_En(MDR_IB_En), .AuxR_Load_En(AuxR_Load_En), .AuxR_Out_En(AuxR_Out_En),
    .Push_Stack(Push_Stack), .Pop_Stack(Pop_Stack), .Halted(Halted), .Fault(Fault),
    .Fault_Code(Fault_Code), .Stack_Level(Stack_Level), .Debug_State(Debug_State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      st;
    logic [16:0]     stb;
    logic [3:0]      alu;
    logic            halted;
    logic            fault;
    logic [2:0]      fc;
    logic [SL_W-1:0] sl;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: current micro-step plus the remaining steps of the instruction.
  int   m_cur, m_sl, m_fc, m_stall, m_hold, m_pend_fc;
  int   m_seq[$];
  int   plan_ir[$];
  int   plan_c[$];
  logic [7:0] cur_ir;
  logic cur_c;
  logic [1:0] cur_mode;
  int   mr_mode;     // 0 always ready, 1 random, 2 never, 3 ready on last allowed stall
  bit   rand_mode, rand_rst;

  // Choose the next instruction and expand it into its micro-step list.
  task automatic start_instr();
    int k, g, s, t;
    logic [7:0] ir;
    logic c;
    if (plan_ir.size() > 0) begin
      ir = 8'(plan_ir.pop_front());
      c  = (plan_c.pop_front() != 0);
    end else begin
      k = $urandom_range(0, 99);
      s = $urandom_range(0, 15);
      c = ($urandom_range(0, 1) == 1);
      if (k < 20)      ir = {4'h2, 4'(s)};
      else if (k < 32) ir = {4'h0, 4'(s)};
      else if (k < 44) ir = {4'h1, 4'(s)};
      else if (k < 56) ir = {4'h3, 4'(s)};
      else if (k < 72) ir = 8'h42;
      else if (k < 84) ir = 8'h41;
      else if (k < 88) ir = {4'h5, 4'(s)};
      else if (k < 94) ir = {4'($urandom_range(6, 15)), 4'(s)};
      else begin
        t  = $urandom_range(3, 16);
        ir = {4'h4, 4'(t == 16 ? 0 : t)};
      end
    end
    g = int'(ir[7:4]);
    s = int'(ir[3:0]);
    m_pend_fc = 0;
    if (g == 0)      m_seq = {1, 2, 3, 4, 5, 6, 7, 8, 9};
    else if (g == 1) m_seq = {1, 2, 3, 4, 5, 6, 10, 11, 12};
    else if (g == 2) m_seq = {1, 2, 3};
    else if (g == 3) begin
      if (s == 1 && !c) m_seq = {1, 2, 3, 14};
      else              m_seq = {1, 2, 3, 4, 5, 6, 13};
    end else if (g == 4 && s == 2) begin
      if (m_sl == STACK_DEPTH) begin m_seq = {1, 2, 3, 18}; m_pend_fc = 1; end
      else m_seq = {1, 2, 3, 15};
    end else if (g == 4 && s == 1) begin
      if (m_sl == 0) begin m_seq = {1, 2, 3, 18}; m_pend_fc = 2; end
      else m_seq = {1, 2, 3, 16};
    end else if (g == 5) m_seq = {1, 2, 3, 17};
    else begin m_seq = {1, 2, 3, 18}; m_pend_fc = 3; end
    cur_ir = ir;
    cur_c  = c;
    if (rand_mode) cur_mode = 2'($urandom_range(0, 3));
  endtask

  // Strobes the micro-step table asks for, edge strobes qualified by adv.
  function automatic obs_t predict(int cur, logic adv, logic mr, logic [7:0] ir);
    obs_t e;
    logic [16:0] s;
    s = '0;
    case (cur)
      0, 4:      begin s[0] = 1'b1; s[6] = adv; end
      1, 5, 8:   begin s[7] = 1'b1; s[9] = adv & mr; end
      2:         begin s[12] = 1'b1; s[3] = adv; s[1] = adv; end
      3:         s[4] = adv && (ir[7:4] == 4'h2);
      6:         begin s[12] = 1'b1; s[13] = adv; s[1] = adv; end
      7, 10:     begin s[14] = 1'b1; s[6] = adv; end
      9:         begin s[12] = 1'b1; s[4] = adv; end
      11:        begin s[5] = 1'b1; s[10] = adv; end
      12:        begin s[11] = 1'b1; s[8] = 1'b1; end
      13:        begin s[14] = 1'b1; s[1] = adv; end
      14:        s[1] = adv;
      15:        s[15] = adv;
      16:        begin s[16] = adv; s[4] = adv; end
      default:   s = '0;
    endcase
    s[2] = (cur != 13);
    e.st = 5'(cur); e.stb = s; e.alu = ir[3:0];
    e.halted = (cur == 17); e.fault = (cur == 18);
    e.fc = 3'(m_fc); e.sl = SL_W'(m_sl);
    return e;
  endfunction

  // Hold reset for n cycles; every strobe must read 0 meanwhile.
  task automatic do_reset(int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      nReset = 1'b0; Resume = 1'b0; Step = 1'b0; IR = cur_ir; C = cur_c;
      e = '0; e.alu = cur_ir[3:0];
      exp_q.push_back(e);
    end
    m_cur = 0; m_sl = 0; m_fc = 0; m_stall = 0; m_hold = 0;
    start_instr();
  endtask

  task automatic cycle();
    logic adv, wt, mr, go, st, rs, tmo;
    @(posedge clk); #1;
    nReset = 1'b1; IR = cur_ir; C = cur_c; Debug_Mode = cur_mode;
    st = ($urandom_range(0, 1) == 1);
    wt = (m_cur == 1 || m_cur == 5 || m_cur == 8 || m_cur == 12);
    case (mr_mode)
      0:       mr = 1'b1;
      1:       mr = ($urandom_range(0, 3) != 0);
      2:       mr = 1'b0;
      default: mr = (m_stall == MEM_TIMEOUT - 1);
    endcase
    rs = (m_cur == 17 && m_hold >= 2) ? 1'b1 : ($urandom_range(0, 49) == 0);
    Step = st; Mem_Ready = mr; Resume = rs;
    case (cur_mode)
      2'd0:    adv = 1'b1;
      2'd1:    adv = (m_cur == 2) ? st : 1'b1;
      2'd2:    adv = wt ? st : 1'b1;
      default: adv = st;
    endcase
    exp_q.push_back(predict(m_cur, adv, mr, cur_ir));
    if (m_cur == 17)      go = rs;
    else if (m_cur == 18) go = 1'b0;
    else                  go = adv && (!wt || mr);
    tmo = wt && adv && !mr && (m_stall + 1 == MEM_TIMEOUT);
    if (wt && adv && !mr) m_stall++;
    if (tmo) begin
      m_cur = 18; m_fc = 4; m_seq.delete(); m_stall = 0; m_hold = 0;
    end else if (go) begin
      if (m_cur == 15) m_sl++;
      if (m_cur == 16) m_sl--;
      m_hold = 0; m_stall = 0;
      if (m_seq.size() == 0) begin
        m_cur = 0;
        start_instr();
      end else begin
        m_cur = m_seq.pop_front();
        if (m_cur == 18) m_fc = m_pend_fc;
      end
    end else m_hold++;
  endtask

  task automatic tick();
    if (m_cur == 18 && m_hold >= 3)                   do_reset(2);
    else if (rand_rst && $urandom_range(0, 399) == 0) do_reset(1);
    else                                              cycle();
  endtask

  // Monitor: compare one predicted vector per cycle, away from the rising edge.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = Debug_State; a.alu = ALU_Cmd; a.halted = Halted; a.fault = Fault;
      a.fc = Fault_Code; a.sl = Stack_Level;
      a.stb = {Pop_Stack, Push_Stack, AuxR_Out_En, AuxR_Load_En, MDR_IB_En, MDR_XB_En,
               MDR_IB_Load, MDR_XB_Load, Write, Read, MAR_Load, ACC_Out_En, ALU_En,
               IR_Load, PC_Inc_nLoad, PC_Load_En, PC_Out_En};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cu_vec %0d @%0t: got st=%0d stb=%05h alu=%h h=%b f=%b fc=%0d sl=%0d; want st=%0d stb=%05h alu=%h h=%b f=%b fc=%0d sl=%0d",
                 vectors, $time, a.st, a.stb, a.alu, a.halted, a.fault, a.fc, a.sl,
                 e.st, e.stb, e.alu, e.halted, e.fault, e.fc, e.sl);
      end
    end
  end

  initial begin
    int guard;
    m_sl = 0; m_fc = 0; m_cur = 0; m_stall = 0; m_hold = 0; m_pend_fc = 0;
    cur_ir = 8'h00; cur_c = 1'b0; cur_mode = 2'd0;
    mr_mode = 0; rand_mode = 1'b0; rand_rst = 1'b0;
    // Directed opening: internal op, not-taken and taken conditional jump,
    // stack overflow, underflow after reset, halt/resume, a load.
    plan_ir.push_back(8'h21); plan_c.push_back(0);
    plan_ir.push_back(8'h31); plan_c.push_back(0);
    plan_ir.push_back(8'h31); plan_c.push_back(1);
    for (int i = 0; i < 17; i++) begin plan_ir.push_back(8'h42); plan_c.push_back(0); end
    plan_ir.push_back(8'h41); plan_c.push_back(0);
    plan_ir.push_back(8'h50); plan_c.push_back(0);
    plan_ir.push_back(8'h05); plan_c.push_back(0);
    do_reset(3);
    #1;
    if (Debug_State !== 5'd0 || Stack_Level !== '0 || Fault_Code !== 3'd0 ||
        Halted !== 1'b0 || Fault !== 1'b0 ||
        {Pop_Stack, Push_Stack, AuxR_Out_En, AuxR_Load_En, MDR_IB_En, MDR_XB_En,
         MDR_IB_Load, MDR_XB_Load, Write, Read, MAR_Load, ACC_Out_En, ALU_En,
         IR_Load, PC_Inc_nLoad, PC_Load_En, PC_Out_En} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_state @%0t: st=%0d sl=%0d fc=%0d h=%b f=%b", $time,
               Debug_State, Stack_Level, Fault_Code, Halted, Fault);
    end
    guard = 0;
    while (plan_ir.size() > 0 && guard < 2000) begin tick(); guard++; end
    repeat (20) tick();
    // Memory never answers: watchdog fault.
    do_reset(1);
    mr_mode = 2;
    guard = 0;
    while (!(m_cur == 18 && m_fc == 4) && guard < 200) begin tick(); guard++; end
    tick();
    if (Fault !== 1'b1 || Fault_Code !== 3'd4 || Debug_State !== 5'd18 || guard >= 200) begin
      miscompares++;
      $display("FAIL wait_expired @%0t: st=%0d f=%b fc=%0d guard=%0d", $time,
               Debug_State, Fault, Fault_Code, guard);
    end
    repeat (45) tick();
    // Memory answers on the last allowed stall cycle.
    do_reset(1);
    mr_mode = 3;
    repeat (80) tick();
    // Micro-step mode with random Step pulses.
    do_reset(1);
    mr_mode = 1; cur_mode = 2'd3;
    repeat (300) tick();
    // Fully random: modes, memory latency, resets.
    rand_mode = 1'b1; rand_rst = 1'b1;
    repeat (4000) tick();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
